// File: rtl/rx_align_multi.sv
`default_nettype none
// ============================================================================
//  Module      : rx_align_multi
//  Description : Walks NCH deserialised LVDS channels in turn, bitslipping each
//                until its word equals PATTERN or MAX_SLIP attempts are spent.
//                Optional macro RX_ALIGN_CONFIRM_EN demands CONFIRM_N
//                consecutive matching words before a channel is accepted.
//  Revision    : 1.0  initial release
// ============================================================================
module rx_align_multi #(
    parameter int             NCH       = 9,
    parameter int             DES       = 4,
    parameter logic [DES-1:0] PATTERN   = 4'b0001,
    parameter int             START_DLY = 16,
    parameter int             SETTLE    = 6,
    parameter int             PULSE_W   = 2,
    parameter int             MAX_SLIP  = 2 * DES,
    localparam int            CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               rxoutclock,
    input  logic               reset_n,
    input  logic               rx_locked,
    input  logic               aligni,
    input  logic [NCH*DES-1:0] rxout,
    output logic [NCH-1:0]     aligno,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [NCH-1:0]     ch_aligned,
    output logic [NCH-1:0]     ch_fail,
    output logic [CHW-1:0]     cur_ch
);

    localparam int SLW    = $clog2(MAX_SLIP + 1);
    localparam int CNT_MX = (SETTLE > PULSE_W) ? SETTLE : PULSE_W;
    localparam int CNW    = $clog2(CNT_MX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_CHECK  = 3'd2,
        S_SLIP   = 3'd3,
        S_NEXT   = 3'd4,
        S_END    = 3'd5
    } state_t;

    state_t               state_q,      state_d;
    logic                 aligni_s_q,   aligni_s_d;
    logic                 aligni_p_q,   aligni_p_d;
    logic [START_DLY-1:0] dly_q,        dly_d;
    logic [CNW-1:0]       cnt_q,        cnt_d;
    logic [SLW-1:0]       slips_q,      slips_d;
    logic [CHW-1:0]       cur_ch_q,     cur_ch_d;
    logic [NCH-1:0]       ch_aligned_q, ch_aligned_d;
    logic [NCH-1:0]       ch_fail_q,    ch_fail_d;
    logic [NCH-1:0]       aligno_q,     aligno_d;
    logic                 busy_q,       busy_d;
    logic                 done_q,       done_d;
    logic                 fail_q,       fail_d;

    logic [DES-1:0]       word;
    logic                 word_match;
    logic                 idle_like;
    logic                 start_rise;
    logic                 start_go;
    logic                 check_ok;
    logic                 check_bad;

    assign word       = rxout[int'(cur_ch_q) * DES +: DES];
    assign word_match = (word == PATTERN);
    assign idle_like  = (state_q == S_IDLE) || (state_q == S_END);
    assign start_rise = aligni_s_q & ~aligni_p_q;
    assign start_go   = dly_q[START_DLY-1] & idle_like;

`ifdef RX_ALIGN_CONFIRM_EN
    localparam int CONFIRM_N = 4;
    localparam int RUNW      = $clog2(CONFIRM_N);

    logic [RUNW-1:0] run_q, run_d;

    // A mismatch anywhere inside the run is a single failed check.
    assign check_ok  = (state_q == S_CHECK) && word_match && (run_q == RUNW'(CONFIRM_N - 1));
    assign check_bad = (state_q == S_CHECK) && !word_match;
`else
    assign check_ok  = (state_q == S_CHECK) && word_match;
    assign check_bad = (state_q == S_CHECK) && !word_match;
`endif

    always_comb begin
        aligni_s_d   = aligni;
        aligni_p_d   = aligni_s_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        slips_d      = slips_q;
        cur_ch_d     = cur_ch_q;
        ch_aligned_d = ch_aligned_q;
        ch_fail_d    = ch_fail_q;
        done_d       = done_q;
        fail_d       = fail_q;
        // Rises seen while busy are dropped here so they cannot restart later.
        dly_d        = (dly_q << 1) | START_DLY'(start_rise && idle_like);

        case (state_q)
            S_IDLE, S_END: begin
                if (start_go) begin
                    state_d      = S_SETTLE;
                    cur_ch_d     = '0;
                    cnt_d        = '0;
                    slips_d      = '0;
                    ch_aligned_d = '0;
                    ch_fail_d    = '0;
                    done_d       = 1'b0;
                    fail_d       = 1'b0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNW'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (check_ok) begin
                    ch_aligned_d[cur_ch_q] = 1'b1;
                    state_d                = S_NEXT;
                end else if (check_bad) begin
                    if (slips_q < SLW'(MAX_SLIP)) begin
                        slips_d = slips_q + 1'b1;
                        cnt_d   = '0;
                        state_d = S_SLIP;
                    end else begin
                        ch_fail_d[cur_ch_q] = 1'b1;
                        state_d             = S_NEXT;
                    end
                end
            end
            S_SLIP: begin
                if (cnt_q == CNW'(PULSE_W - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_NEXT: begin
                slips_d = '0;
                cnt_d   = '0;
                if (cur_ch_q == CHW'(NCH - 1)) begin
                    state_d = S_END;
                    done_d  = &ch_aligned_q;
                    fail_d  = |ch_fail_q;
                end else begin
                    cur_ch_d = cur_ch_q + 1'b1;
                    state_d  = S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Lock loss aborts outright; relock needs a fresh aligni rise.
        if (!rx_locked) begin
            state_d      = S_IDLE;
            dly_d        = '0;
            cnt_d        = '0;
            slips_d      = '0;
            cur_ch_d     = '0;
            ch_aligned_d = '0;
            ch_fail_d    = '0;
            done_d       = 1'b0;
            fail_d       = 1'b0;
        end

        busy_d   = (state_d != S_IDLE) && (state_d != S_END);
        aligno_d = (state_d == S_SLIP) ? (NCH'(1) << cur_ch_d) : '0;
    end

`ifdef RX_ALIGN_CONFIRM_EN
    always_comb begin
        run_d = '0;
        if (state_d == S_CHECK && state_q == S_CHECK && word_match) begin
            run_d = run_q + RUNW'(1);
        end
    end
`endif

    always_ff @(posedge rxoutclock) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            aligni_s_q   <= 1'b0;
            aligni_p_q   <= 1'b0;
            dly_q        <= '0;
            cnt_q        <= '0;
            slips_q      <= '0;
            cur_ch_q     <= '0;
            ch_aligned_q <= '0;
            ch_fail_q    <= '0;
            aligno_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
`ifdef RX_ALIGN_CONFIRM_EN
            run_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            aligni_s_q   <= aligni_s_d;
            aligni_p_q   <= aligni_p_d;
            dly_q        <= dly_d;
            cnt_q        <= cnt_d;
            slips_q      <= slips_d;
            cur_ch_q     <= cur_ch_d;
            ch_aligned_q <= ch_aligned_d;
            ch_fail_q    <= ch_fail_d;
            aligno_q     <= aligno_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
`ifdef RX_ALIGN_CONFIRM_EN
            run_q        <= run_d;
`endif
        end
    end

    assign aligno     = aligno_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign ch_aligned = ch_aligned_q;
    assign ch_fail    = ch_fail_q;
    assign cur_ch     = cur_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_align_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_align_multi
//  Description : Table-driven scoreboard bench for rx_align_multi with a
//                rotating-word channel model; honours RX_ALIGN_CONFIRM_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rx_align_multi;

    localparam int             NCH       = 9;
    localparam int             DES       = 4;
    localparam logic [DES-1:0] PATTERN   = 4'b0001;
    localparam int             START_DLY = 16;
    localparam int             SETTLE    = 6;
    localparam int             PULSE_W   = 2;
    localparam int             MAX_SLIP  = 2 * DES;
    localparam int             CHW       = 4;
    localparam int             SLIP_COST = PULSE_W + SETTLE + 1;
`ifdef RX_ALIGN_CONFIRM_EN
    localparam int             CHK_EXTRA = 3;
`else
    localparam int             CHK_EXTRA = 0;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic               rx_locked;
    logic               aligni;
    logic [NCH*DES-1:0] rxout;
    logic [NCH-1:0]     aligno;
    logic               busy;
    logic               done;
    logic               fail;
    logic [NCH-1:0]     ch_aligned;
    logic [NCH-1:0]     ch_fail;
    logic [CHW-1:0]     cur_ch;

    always #5 clk = ~clk;

    rx_align_multi #(
        .NCH(NCH), .DES(DES), .PATTERN(PATTERN), .START_DLY(START_DLY),
        .SETTLE(SETTLE), .PULSE_W(PULSE_W), .MAX_SLIP(MAX_SLIP)
    ) dut (
        .rxoutclock(clk),
        .reset_n(reset_n),
        .rx_locked(rx_locked),
        .aligni(aligni),
        .rxout(rxout),
        .aligno(aligno),
        .busy(busy),
        .done(done),
        .fail(fail),
        .ch_aligned(ch_aligned),
        .ch_fail(ch_fail),
        .cur_ch(cur_ch)
    );

    // Channel model: word is PATTERN once enough slips arrived, else a non-zero rotation.
    logic [NCH-1:0][3:0] cur_need = '0;
    int                  pcnt  [NCH] = '{default: 0};
    int                  hcnt  [NCH] = '{default: 0};
    int                  pbase [NCH] = '{default: 0};
    int                  hbase [NCH] = '{default: 0};
    logic [NCH-1:0]      aligno_prev = '0;
    int                  onehot_err = 0;
    bit                  glitch0 = 1'b0;

    function automatic logic [DES-1:0] model_word(input int n, input int p);
        logic [2*DES-1:0] dbl;
        int               r;
        if (p >= n) return PATTERN;
        r   = 1 + ((n - p - 1) % (DES - 1));
        dbl = {PATTERN, PATTERN} << r;
        return dbl[2*DES-1 -: DES];
    endfunction

    always_comb begin
        rxout = '0;
        for (int k = 0; k < NCH; k++) begin
            rxout[k*DES +: DES] = model_word(int'(cur_need[k]), pcnt[k] - pbase[k]);
        end
        if (glitch0) rxout[DES-1:0] = ~PATTERN;
    end

    always @(negedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (aligno[k] && !aligno_prev[k]) pcnt[k]++;
            if (aligno[k]) hcnt[k]++;
        end
        if ($countones(aligno) > 1) onehot_err++;
        aligno_prev = aligno;
    end

    typedef struct packed {
        logic [NCH-1:0][3:0] need;
        logic [NCH-1:0]      al;
        logic [NCH-1:0]      fl;
        logic                dn;
        logic                fa;
    } vec_t;

    typedef struct packed {
        logic [NCH-1:0]      al;
        logic [NCH-1:0]      fl;
        logic                dn;
        logic                fa;
        int                  lat;
        logic [NCH-1:0][7:0] pulses;
    } exp_t;

    exp_t exp_q [$];
    vec_t vecs  [6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int calc_lat(input logic [NCH-1:0][3:0] nd);
        int t = START_DLY + 2;
        for (int k = 0; k < NCH; k++) begin
            if (int'(nd[k]) > MAX_SLIP) t += SETTLE + 2 + MAX_SLIP * SLIP_COST;
            else                        t += SETTLE + 2 + CHK_EXTRA + int'(nd[k]) * SLIP_COST;
        end
        return t;
    endfunction

    task automatic rebase();
        for (int k = 0; k < NCH; k++) begin
            pbase[k] = pcnt[k];
            hbase[k] = hcnt[k];
        end
    endtask

    // Pulses aligni and waits for the sequence to finish; lat counts negedges from the rise.
    task automatic run_seq(input int extra_at, input int glitch_k, output int lat, output bit to);
        int n = 0;
        int k = -1;
        bit seen = 1'b0;
        to = 1'b0;
        @(negedge clk);
        aligni = 1'b1;
        while (1) begin
            @(negedge clk);
            n++;
            if (n == 3) aligni = 1'b0;
            if (extra_at > 0 && n == extra_at)     aligni = 1'b1;
            if (extra_at > 0 && n == extra_at + 3) aligni = 1'b0;
            if (!seen && busy) begin
                seen = 1'b1;
                k    = 0;
            end else if (seen) begin
                k++;
            end
            if (seen && glitch_k >= 0 && k == glitch_k)     glitch0 = 1'b1;
            if (seen && glitch_k >= 0 && k == glitch_k + 1) glitch0 = 1'b0;
            if (seen && (done || fail)) break;
            if (n > 3000) begin
                to = 1'b1;
                break;
            end
        end
        lat = n;
    endtask

    task automatic apply(input vec_t v, input int extra_at, input int glitch_k,
                         input int lat_adj, input int p0_adj, input string tag);
        exp_t e;
        exp_t got;
        int   lat;
        bit   to;
        @(negedge clk);
        cur_need = v.need;
        rebase();
        e.al  = v.al;
        e.fl  = v.fl;
        e.dn  = v.dn;
        e.fa  = v.fa;
        e.lat = calc_lat(v.need) + lat_adj;
        for (int k = 0; k < NCH; k++) begin
            e.pulses[k] = 8'((int'(v.need[k]) > MAX_SLIP) ? MAX_SLIP : int'(v.need[k]));
        end
        e.pulses[0] = e.pulses[0] + 8'(p0_adj);
        exp_q.push_back(e);
        run_seq(extra_at, glitch_k, lat, to);
        chk({tag, " timeout"}, 64'(to), 64'd0);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got empty queue expected entry", tag);
            return;
        end
        got = exp_q.pop_front();
        chk({tag, " done"},       64'(done),       64'(got.dn));
        chk({tag, " fail"},       64'(fail),       64'(got.fa));
        chk({tag, " ch_aligned"}, 64'(ch_aligned), 64'(got.al));
        chk({tag, " ch_fail"},    64'(ch_fail),    64'(got.fl));
        chk({tag, " busy"},       64'(busy),       64'd0);
        chk({tag, " latency"},    64'(lat),        64'(got.lat));
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("%s pulses ch%0d", tag, k), 64'(pcnt[k] - pbase[k]), 64'(got.pulses[k]));
            chk($sformatf("%s pulse_cycles ch%0d", tag, k), 64'(hcnt[k] - hbase[k]),
                64'(int'(got.pulses[k]) * PULSE_W));
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({aligno, busy, done, fail, ch_aligned, ch_fail, cur_ch});
    endfunction

    initial begin
        vec_t v;
        int   n;

        for (int i = 0; i < 6; i++) vecs[i] = '0;
        vecs[0].al = 9'h1FF; vecs[0].dn = 1'b1;
        vecs[1].need[3] = 4'd2;  vecs[1].al = 9'h1FF; vecs[1].dn = 1'b1;
        vecs[2].need[5] = 4'd15; vecs[2].al = 9'h1DF; vecs[2].fl = 9'h020; vecs[2].fa = 1'b1;
        vecs[3].need[8] = 4'd8;  vecs[3].al = 9'h1FF; vecs[3].dn = 1'b1;
        vecs[4].need[0] = 4'd1;  vecs[4].need[2] = 4'd3; vecs[4].need[7] = 4'd15;
        vecs[4].al = 9'h17F; vecs[4].fl = 9'h080; vecs[4].fa = 1'b1;
        vecs[5].need[1] = 4'd9;  vecs[5].need[8] = 4'd15;
        vecs[5].al = 9'h0FD; vecs[5].fl = 9'h102; vecs[5].fa = 1'b1;

        reset_n   = 1'b0;
        rx_locked = 1'b1;
        aligni    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs", all_outs(), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            apply(vecs[i], 0, -1, 0, 0, $sformatf("vec%0d", i));
        end

        // Rise during busy must neither disturb nor later restart the sequence.
        apply(vecs[0], 40, -1, 0, 0, "busy_rise");
        repeat (START_DLY + 8) @(negedge clk);
        chk("busy_rise no restart busy", 64'(busy), 64'd0);
        chk("busy_rise no restart done", 64'(done), 64'd1);

        // Lock loss while slipping channel 4.
        cur_need = '0;
        cur_need[4] = 4'd2;
        rebase();
        aligni = 1'b1;
        n = 0;
        while (!aligno[4] && n < 500) begin
            @(negedge clk);
            n++;
            if (n == 3) aligni = 1'b0;
        end
        aligni = 1'b0;
        chk("lockdrop reached slip", 64'(aligno[4]), 64'd1);
        chk("lockdrop cur_ch", 64'(cur_ch), 64'd4);
        rx_locked = 1'b0;
        @(negedge clk);
        chk("lockdrop outputs", all_outs(), 64'd0);
        repeat (20) @(negedge clk);
        chk("lockdrop stays idle", all_outs(), 64'd0);
        rx_locked = 1'b1;
        repeat (2) @(negedge clk);
        v = '0;
        v.need[4] = 4'd2; v.al = 9'h1FF; v.dn = 1'b1;
        apply(v, 0, -1, 0, 0, "relock");

        // Reset in the middle of a run.
        @(negedge clk);
        cur_need = '0;
        aligni = 1'b1;
        repeat (3) @(negedge clk);
        aligni = 1'b0;
        repeat (50) @(negedge clk);
        chk("midrun busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrun reset outputs", all_outs(), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef RX_ALIGN_CONFIRM_EN
        // Three matching compares, then a glitch on the fourth: one slip on ch 0.
        v = '0;
        v.al = 9'h1FF; v.dn = 1'b1;
        apply(v, 0, 9, CHK_EXTRA + SLIP_COST, 1, "confirm_glitch");
`endif

        chk("aligno onehot", 64'(onehot_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
